// File: rtl/mux_arb.sv
// mux_arb: N-channel registered mux with valid/ready handshake.
// Steering is either an external select (MODE 0) or round-robin arbitration (MODE 1).
module mux_arb #(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = 0,
    parameter int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int PW = $clog2(N);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt;
    logic [W-1:0]  gnt_data;
    logic          gnt_ok, load, xfer;
    int            j;

    always_comb begin
        gnt      = '0;
        gnt_ok   = 1'b0;
        gnt_data = '0;
        j        = 0;
        // Descending scan so the channel closest above ptr is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (MODE == 0 && int'(sel) == k && in_valid[PW'(k)]) begin
                gnt    = PW'(k);
                gnt_ok = 1'b1;
            end
            if (MODE != 0 && in_valid[PW'(j)]) begin
                gnt    = PW'(j);
                gnt_ok = 1'b1;
            end
        end
        for (int k = 0; k < N; k++)
            if (gnt == PW'(k)) gnt_data = in_data[k*W +: W];
        load        = !out_valid_q || out_ready;
        xfer        = load && gnt_ok && !rst;
        in_ready    = xfer ? N'(1) << gnt : '0;
        out_valid_d = load ? xfer : out_valid_q;
        out_data_d  = xfer ? gnt_data : out_data_q;
        out_ch_d    = xfer ? SW'(gnt) : out_ch_q;
        ptr_d       = (MODE != 0 && xfer) ? (gnt == PW'(N - 1) ? '0 : gnt + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: fixed-select (N=4, N=3) and round-robin (N=4) instances checked against a behavioural model.
module tb_mux_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [127:0] d_a, d_c;
    logic [95:0]  d_b;
    logic [3:0]   v_a, v_c, r_a, r_c;
    logic [2:0]   v_b, r_b;
    logic [1:0]   s_a, s_b, s_c, oc_a, oc_b, oc_c;
    logic [31:0]  od_a, od_b, od_c;
    logic         ov_a, ov_b, ov_c, ordy_a, ordy_b, ordy_c;

    mux_arb #(.N(4), .W(32), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(d_a), .in_valid(v_a), .in_ready(r_a), .sel(s_a),
        .out_data(od_a), .out_ch(oc_a), .out_valid(ov_a), .out_ready(ordy_a));
    mux_arb #(.N(3), .W(32), .MODE(0), .SW(2)) u_b (
        .clk(clk), .rst(rst), .in_data(d_b), .in_valid(v_b), .in_ready(r_b), .sel(s_b),
        .out_data(od_b), .out_ch(oc_b), .out_valid(ov_b), .out_ready(ordy_b));
    mux_arb #(.N(4), .W(32), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(d_c), .in_valid(v_c), .in_ready(r_c), .sel(s_c),
        .out_data(od_c), .out_ch(oc_c), .out_valid(ov_c), .out_ready(ordy_c));

    task automatic set_default_data();
        for (int i = 0; i < 4; i++) begin
            d_a[i*32 +: 32] = 32'hA0 + 32'(i);
            d_c[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        for (int i = 0; i < 3; i++) d_b[i*32 +: 32] = 32'hA0 + 32'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v_a = '1; v_b = '1; v_c = '1;
        ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1;
        s_a = 2'd0; s_b = 2'd0; s_c = 2'd0;
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if ({ov_a, ov_b, ov_c} !== 3'b000 || od_a !== 32'h0 || od_b !== 32'h0 || od_c !== 32'h0 ||
                oc_a !== 2'd0 || oc_b !== 2'd0 || oc_c !== 2'd0) begin
                errors++;
                $display("FAIL reset_out: ov=%b%b%b od=%h/%h/%h oc=%0d/%0d/%0d, want all 0",
                         ov_a, ov_b, ov_c, od_a, od_b, od_c, oc_a, oc_b, oc_c);
            end
            checks++;
            if ({r_a, r_b, r_c} !== 11'b0) begin
                errors++;
                $display("FAIL reset_ready: r=%b/%b/%b, want 0", r_a, r_b, r_c);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (r_a !== 4'b0001 || r_b !== 3'b001 || r_c !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release_ready: r=%b/%b/%b, want 0001/001/0001", r_a, r_b, r_c);
        end
        @(negedge clk); #1;
        checks++;
        if (ov_a !== 1'b1 || od_a !== 32'hA0 || oc_a !== 2'd0 || ov_c !== 1'b1 || od_c !== 32'hA0 || oc_c !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_xfer: a=%b/%h/%0d c=%b/%h/%0d, want 1/a0/0", ov_a, od_a, oc_a, ov_c, od_c, oc_c);
        end
    endtask

    task automatic test_fixed();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            s_a = 2'(s);
            #1;
            checks++;
            if (r_a !== 4'(1 << s)) begin
                errors++;
                $display("FAIL fixed_ready sel=%0d: got %b want %b", s, r_a, 4'(1 << s));
            end
            @(posedge clk); #1;
            checks++;
            if (od_a !== 32'hA0 + 32'(s) || oc_a !== 2'(s) || ov_a !== 1'b1) begin
                errors++;
                $display("FAIL fixed_out sel=%0d: got %h/%0d/%b want %h/%0d/1", s, od_a, oc_a, ov_a, 32'hA0 + 32'(s), s);
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        s_b = 2'd3;
        #1;
        checks++;
        if (r_b !== 3'b000) begin
            errors++;
            $display("FAIL oor_ready: got %b want 000", r_b);
        end
        @(posedge clk); #1;
        checks++;
        if (ov_b !== 1'b0 || od_b !== 32'hA0 || oc_b !== 2'd0) begin
            errors++;
            $display("FAIL oor_out: got %b/%h/%0d want 0/a0/0", ov_b, od_b, oc_b);
        end
        s_b = 2'd0;
    endtask

    task automatic test_rr_fair();
        v_c = 4'b1111;
        ordy_c = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (oc_c !== 2'(i % 4) || ov_c !== 1'b1 || od_c !== 32'hA0 + 32'(i % 4)) begin
                errors++;
                $display("FAIL rr_fair step %0d: got ch=%0d v=%b d=%h want ch=%0d v=1", i, oc_c, ov_c, od_c, i % 4);
            end
        end
    endtask

    task automatic test_rr_skip_wrap();
        int exp_ch;
        v_c = 4'b1010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 1) ? 3 : 1;
            @(posedge clk); #1;
            checks++;
            if (oc_c !== 2'(exp_ch) || ov_c !== 1'b1 || u_c.ptr_q !== 2'((exp_ch + 1) % 4)) begin
                errors++;
                $display("FAIL rr_skip step %0d: got ch=%0d v=%b ptr=%0d want ch=%0d ptr=%0d",
                         i, oc_c, ov_c, u_c.ptr_q, exp_ch, (exp_ch + 1) % 4);
            end
        end
    endtask

    task automatic test_back_pressure();
        v_c = 4'b0100;
        d_c[64 +: 32] = 32'h55;
        ordy_c = 1'b1;
        do_reset();
        @(negedge clk);
        v_c = 4'b0001;
        d_c[0 +: 32] = 32'h11;
        ordy_c = 1'b0;
        #1;
        checks++;
        if (od_c !== 32'h55 || oc_c !== 2'd2 || ov_c !== 1'b1 || r_c !== 4'b0000) begin
            errors++;
            $display("FAIL bp_load: got %h/%0d/%b ready=%b want 55/2/1 ready=0000", od_c, oc_c, ov_c, r_c);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (od_c !== 32'h55 || oc_c !== 2'd2 || ov_c !== 1'b1 || r_c !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall: got %h/%0d/%b ready=%b want 55/2/1 ready=0000", od_c, oc_c, ov_c, r_c);
            end
        end
        @(negedge clk);
        ordy_c = 1'b1;
        #1;
        checks++;
        if (r_c !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0001", r_c);
        end
        @(posedge clk); #1;
        checks++;
        if (od_c !== 32'h11 || oc_c !== 2'd0 || ov_c !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_fill: got %h/%0d/%b want 11/0/1", od_c, oc_c, ov_c);
        end
        set_default_data();
    endtask

    task automatic test_random();
        int mp, mc, mcb, g, sb;
        logic mv, mvb, ld, okb;
        logic [31:0] md, mdb;
        logic [3:0] exp_rc;
        logic [2:0] exp_rb;
        v_b = '0; v_c = '0;
        ordy_b = 1'b1; ordy_c = 1'b1;
        do_reset();
        mp = 0; mc = 0; mv = 1'b0; md = '0;
        mcb = 0; mvb = 1'b0; mdb = '0;
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            v_c = 4'($urandom);
            v_b = 3'($urandom);
            s_b = 2'($urandom_range(0, 3));
            ordy_c = ($urandom_range(0, 3) != 0);
            ordy_b = ($urandom_range(0, 3) != 0);
            d_c = {$urandom, $urandom, $urandom, $urandom};
            d_b = {$urandom, $urandom, $urandom};
            #1;
            // round-robin reference: first valid channel at or after the pointer
            ld = !mv || ordy_c;
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && v_c[(mp + k) % 4]) g = (mp + k) % 4;
            exp_rc = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
            checks++;
            if (r_c !== exp_rc) begin
                errors++;
                $display("FAIL rand_rr_ready it=%0d: got %b want %b (valid=%b ptr=%0d)", it, r_c, exp_rc, v_c, mp);
            end
            if (ld) begin
                if (g >= 0) begin
                    md = 32'(d_c >> (g * 32));
                    mc = g;
                    mv = 1'b1;
                    mp = (g + 1) % 4;
                end else mv = 1'b0;
            end
            sb = int'(s_b);
            okb = (sb < 3) && (((v_b >> sb) & 3'd1) != 3'd0);
            ld = !mvb || ordy_b;
            exp_rb = (ld && okb) ? 3'(1 << sb) : 3'b0;
            checks++;
            if (r_b !== exp_rb) begin
                errors++;
                $display("FAIL rand_fix_ready it=%0d: got %b want %b (sel=%0d valid=%b)", it, r_b, exp_rb, sb, v_b);
            end
            if (ld) begin
                if (okb) begin
                    mdb = 32'(d_b >> (sb * 32));
                    mcb = sb;
                    mvb = 1'b1;
                end else mvb = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (ov_c !== mv || od_c !== md || oc_c !== 2'(mc)) begin
                errors++;
                $display("FAIL rand_rr_out it=%0d: got %b/%h/%0d want %b/%h/%0d", it, ov_c, od_c, oc_c, mv, md, mc);
            end
            checks++;
            if (ov_b !== mvb || od_b !== mdb || oc_b !== 2'(mcb)) begin
                errors++;
                $display("FAIL rand_fix_out it=%0d: got %b/%h/%0d want %b/%h/%0d", it, ov_b, od_b, oc_b, mvb, mdb, mcb);
            end
        end
    endtask

    initial begin
        set_default_data();
        test_reset();
        test_fixed();
        test_out_of_range();
        test_rr_fair();
        test_rr_skip_wrap();
        test_back_pressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
